// File: rtl/homog_divide.sv
// Homogeneous divide: (x, y, z, w) -> (x/w, y/w, z/w) through one shared restoring divider.
// Define HDIV_ROUND_EN to round half away from zero instead of truncating toward zero.
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// LOAD  | set up dividend/divisor/sign for component idx
// DIV   | D restoring-division steps, one quotient bit per cycle
// FIX   | round/saturate, apply sign, write out_vec[idx]
// DONE  | result presented until out_ready
module homog_divide #(
    parameter int WI = 9,
    parameter int WF = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0][WI+WF-1:0]       in_vec,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2:0][WI+WF-1:0]       out_vec,
    output logic                        div_err,
    output logic                        sat
);
    localparam int W  = WI + WF;
    localparam int D  = W + WF;
    localparam int CW = $clog2(D);

    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [D:0]   MAX_Q = {{(D-W+2){1'b0}}, {(W-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, LOAD, DIV, FIX, DONE} state_t;

    state_t              state;
    logic [3:0][W-1:0]   vec;
    logic [1:0]          idx;
    logic [D-1:0]        dvd;
    logic [W-1:0]        rem;
    logic [W-1:0]        dsr;
    logic                sgn;
    logic [CW-1:0]       cnt;

    logic [W-1:0] num, wv, abs_num, abs_w, rem_sub, mag, res_val, fix_val;
    logic [W:0]   trial;
    logic [D:0]   q_full;
    logic         w_zero, fits, over;
`ifdef HDIV_ROUND_EN
    logic         rnd_up;
`endif

    always_comb begin
        num     = vec[idx];
        wv      = vec[3];
        // Unsigned W-bit magnitude is exact even for the most negative input.
        abs_num = num[W-1] ? -num : num;
        abs_w   = wv[W-1] ? -wv : wv;
        w_zero  = (wv == '0);
        trial   = {rem, dvd[D-1]};
        fits    = (trial >= {1'b0, dsr});
        rem_sub = trial[W-1:0] - dsr;
`ifdef HDIV_ROUND_EN
        rnd_up  = ({rem, 1'b0} >= {1'b0, dsr});
        q_full  = {1'b0, dvd} + {{D{1'b0}}, rnd_up};
`else
        q_full  = {1'b0, dvd};
`endif
        over    = (q_full > MAX_Q);
        mag     = over ? MAX_V : q_full[W-1:0];
        res_val = sgn ? -mag : mag;
        if (w_zero)
            fix_val = (num == '0) ? '0 : (num[W-1] ? -MAX_V : MAX_V);
        else
            fix_val = res_val;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_vec   <= '0;
            div_err   <= 1'b0;
            sat       <= 1'b0;
            vec       <= '0;
            idx       <= '0;
            dvd       <= '0;
            rem       <= '0;
            dsr       <= '0;
            sgn       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec      <= in_vec;
                        idx      <= '0;
                        div_err  <= 1'b0;
                        sat      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    dvd   <= {abs_num, {WF{1'b0}}};
                    dsr   <= abs_w;
                    sgn   <= num[W-1] ^ wv[W-1];
                    rem   <= '0;
                    cnt   <= CW'(D - 1);
                    state <= DIV;
                end
                DIV: begin
                    rem <= fits ? rem_sub : trial[W-1:0];
                    dvd <= {dvd[D-2:0], fits};
                    if (cnt == '0)
                        state <= FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                FIX: begin
                    out_vec[idx] <= fix_val;
                    if (w_zero)
                        div_err <= 1'b1;
                    else if (over)
                        sat <= 1'b1;
                    if (idx == 2'd2) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_homog_divide.sv
// Self-checking bench for homog_divide: integer reference model, per-cycle compare, directed literals.
module tb_homog_divide;
    localparam int W = 25;
    localparam int L = 129;
    localparam longint MAXL = 64'd16777215;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
        logic         err;
        logic         s;
    } res_t;

    logic              clk = 0;
    logic              resetn = 0;
    logic              in_valid = 0;
    logic              in_ready;
    logic [3:0][W-1:0] in_vec = '0;
    logic              out_valid;
    logic              out_ready = 0;
    logic [2:0][W-1:0] out_vec;
    logic              div_err;
    logic              sat;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   hold = 0;
    bit   busy = 0;
    int   acc_cyc = 0;
    res_t expq[$];

    homog_divide #(.WI(9), .WF(16)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .div_err(div_err), .sat(sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (t=%0t)", name, $time);
    endtask

    function automatic logic [W-1:0] comp(input logic [W-1:0] n, input logic [W-1:0] w, output bit s);
        longint nv, wv, an, aw, q, r, res;
        logic [63:0] tmp;
        nv = longint'($signed(n));
        wv = longint'($signed(w));
        s = 0;
        if (wv == 0) begin
            res = (nv == 0) ? 0 : ((nv < 0) ? -MAXL : MAXL);
        end else begin
            an = (nv < 0) ? -nv : nv;
            aw = (wv < 0) ? -wv : wv;
            q = (an * 65536) / aw;
            r = (an * 65536) % aw;
`ifdef HDIV_ROUND_EN
            if (2 * r >= aw) q++;
`endif
            if (q > MAXL) begin
                q = MAXL;
                s = 1;
            end
            res = ((nv < 0) != (wv < 0)) ? -q : q;
        end
        tmp = res;
        return tmp[W-1:0];
    endfunction

    function automatic res_t model(input logic [3:0][W-1:0] v);
        res_t e;
        bit s0, s1, s2;
        e.x = comp(v[0], v[3], s0);
        e.y = comp(v[1], v[3], s1);
        e.z = comp(v[2], v[3], s2);
        e.err = (v[3] == '0);
        e.s = s0 | s1 | s2;
        return e;
    endfunction

    // Per-cycle compare against the model; acceptance/handshake are decided at the following edge.
    always @(negedge clk) begin
        bit   exp_v;
        res_t e;
        if (!resetn) begin
            busy = 0;
            expq.delete();
        end else begin
            check("in_ready", in_ready, !busy);
            exp_v = busy && (cyc >= acc_cyc + L);
            check("out_valid", out_valid, exp_v);
            if (exp_v && expq.size() > 0) begin
                e = expq[0];
                check("out_x", out_vec[0], e.x);
                check("out_y", out_vec[1], e.y);
                check("out_z", out_vec[2], e.z);
                check("div_err", div_err, e.err);
                check("sat", sat, e.s);
            end
            if (exp_v && out_valid && out_ready) begin
                busy = 0;
                if (expq.size() > 0) void'(expq.pop_front());
            end
            if (!busy && in_valid && in_ready) begin
                busy = 1;
                acc_cyc = cyc + 1;
                expq.push_back(model(in_vec));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [3:0][W-1:0] v);
        int n = 0;
        in_vec = v;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_timeout("accept");
        @(posedge clk);
        #1;
        in_valid = 0;
        for (int i = 0; i < 4; i++) in_vec[i] = W'($urandom);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 400);
        if (!out_valid) fail_timeout("out_valid");
    endtask

    task automatic check_out(input string name, input logic [W-1:0] ex, input logic [W-1:0] ey,
                             input logic [W-1:0] ez, input logic ee, input logic es);
        check({name, "_x"}, out_vec[0], ex);
        check({name, "_y"}, out_vec[1], ey);
        check({name, "_z"}, out_vec[2], ez);
        check({name, "_err"}, div_err, ee);
        check({name, "_sat"}, sat, es);
    endtask

    function automatic logic [3:0][W-1:0] mk(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] z, input logic [W-1:0] w);
        logic [3:0][W-1:0] v;
        v[0] = x; v[1] = y; v[2] = z; v[3] = w;
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_val(input bit allow_zero);
        logic [W-1:0] t;
        t = W'($urandom);
        case ($urandom_range(0, 3))
            0: t = {{5{t[19]}}, t[19:0]};
            1: t = {{9{t[15]}}, t[15:0]};
            2: if (allow_zero) t = '0;
            default: ;
        endcase
        return t;
    endfunction

    initial begin
        int n;
        bit s;
        logic [W-1:0] rx;
        logic [3:0][W-1:0] v;

        // Pin the reference model with hand-computed values.
        check("model_frac", comp(25'h0030000, 25'h0020000, s), 25'h0018000);
        check("model_neg", comp(25'h1FD0000, 25'h0020000, s), 25'h1FE8000);
        check("model_zero_w", comp(25'h1FB0000, 25'h0000000, s), 25'h1000001);
        rx = comp(25'h0C80000, 25'h0004000, s);
        check("model_sat", {rx, s}, {25'h0FFFFFF, 1'b1});

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_vec", out_vec, 0);
        check("rst_flags", {div_err, sat}, 0);
        @(posedge clk);
        #1 resetn = 1;

        send(mk(25'h0000000, 25'h1FF0000, 25'h0000000, 25'h0010000));
        wait_out(n);
        check("identity_latency", n - 1, L);
        check_out("identity", 25'h0000000, 25'h1FF0000, 25'h0000000, 0, 0);

        send(mk(25'h0030000, 25'h1FD0000, 25'h0010000, 25'h0020000));
        wait_out(n);
        check_out("frac", 25'h0018000, 25'h1FE8000, 25'h0008000, 0, 0);

        send(mk(25'h0050000, 25'h1FB0000, 25'h0000000, 25'h0000000));
        wait_out(n);
        check("divzero_latency", n - 1, L);
        check_out("divzero", 25'h0FFFFFF, 25'h1000001, 25'h0000000, 1, 0);

        send(mk(25'h0C80000, 25'h0000000, 25'h0000000, 25'h0004000));
        wait_out(n);
        check_out("saturate", 25'h0FFFFFF, 25'h0000000, 25'h0000000, 0, 1);

        send(mk(25'h0000002, 25'h0000000, 25'h0000000, 25'h0030000));
        wait_out(n);
`ifdef HDIV_ROUND_EN
        check_out("round", 25'h0000001, 25'h0000000, 25'h0000000, 0, 0);
`else
        check_out("round", 25'h0000000, 25'h0000000, 25'h0000000, 0, 0);
`endif

        // Hold the result in DONE while a second vector is offered.
        hold = 1;
        send(mk(25'h1000000, 25'h0FFFFFF, 25'h0012345, 25'h1FF0000));
        wait_out(n);
        in_vec = mk(25'h0030000, 25'h0030000, 25'h0030000, 25'h0030000);
        in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        hold = 0;
        send(mk(25'h0030000, 25'h0030000, 25'h0030000, 25'h0030000));
        wait_out(n);
        check_out("after_hold", 25'h0010000, 25'h0010000, 25'h0010000, 0, 0);

        // Reset in the middle of a division.
        send(mk(25'h0050000, 25'h0060000, 25'h0070000, 25'h0020000));
        repeat (50) @(posedge clk);
        #2 resetn = 0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_vec", out_vec, 0);
        check("midrst_flags", {div_err, sat}, 0);
        @(negedge clk);
        @(posedge clk);
        #1 resetn = 1;
        send(mk(25'h0030000, 25'h1FD0000, 25'h0010000, 25'h0020000));
        wait_out(n);
        check("postrst_latency", n - 1, L);
        check_out("postrst", 25'h0018000, 25'h1FE8000, 25'h0008000, 0, 0);

        for (int k = 0; k < 40; k++) begin
            v[0] = rnd_val(1);
            v[1] = rnd_val(1);
            v[2] = rnd_val(1);
            v[3] = ($urandom_range(0, 7) == 0) ? '0 : rnd_val(0);
            if (v[3] == '0 && $urandom_range(0, 1) == 1) v[3] = 25'h0010000;
            send(v);
        end

        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_timeout("drain");
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
